// File: rtl/rgb_pwm_encoder.sv
// ---------------------------------------------------------------------------
// rgb_pwm_encoder
// Three-channel PWM encoder for the RGB LED pins. Duty words are double
// buffered: a load lands in a pending bank and is copied into the active
// bank only on the edge that enters cnt == 0, so every PWM period is
// generated from one consistent set of duty values.
//
// State table:
//   state  | meaning
//   S_IDLE | counter held at 0, pins at idle level, waiting for enable
//   S_RUN  | generating PWM, period_start pulses at cnt == 0
//   S_STOP | enable dropped; finishing the current period, then IDLE
//
// Ports:
//   clk_div          PWM tick clock
//   rst              asynchronous active-high reset
//   i_enable         level, 1 = run, 0 = stop at end of current period
//   i_load           1-cycle strobe, capture i_*_duty
//   i_r/g/b_duty     duty words (high cycles per period)
//   o_pwm_r/g/b      PWM pins (complemented when INVERT = 1)
//   o_period_start   high for the cnt == 0 cycle while in S_RUN
//   o_pending        pending bank holds a load not yet applied
// ---------------------------------------------------------------------------
module rgb_pwm_encoder #(
    parameter int WIDTH  = 8,
    parameter bit INVERT = 1'b0
) (
    input  logic             clk_div,
    input  logic             rst,
    input  logic             i_enable,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_r_duty,
    input  logic [WIDTH-1:0] i_g_duty,
    input  logic [WIDTH-1:0] i_b_duty,
    output logic             o_pwm_r,
    output logic             o_pwm_g,
    output logic             o_pwm_b,
    output logic             o_period_start,
    output logic             o_pending
);

    // Period is 2**WIDTH-1 cycles, so the last count is 2**WIDTH-2.
    localparam logic [WIDTH-1:0] CNT_LAST = {{(WIDTH-1){1'b1}}, 1'b0};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_STOP = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_cnt;
    logic [WIDTH-1:0] w_next_cnt;
    logic             w_wrap;
    logic             w_update;
    logic             w_start;

    logic [WIDTH-1:0] r_act_r, r_act_g, r_act_b;
    logic [WIDTH-1:0] r_pend_r, r_pend_g, r_pend_b;
    logic             r_pending;
    logic             r_period_start;

    assign w_wrap = (r_cnt == CNT_LAST);

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        w_update     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_next_cnt = '0;
                if (i_enable) begin
                    w_next_state = S_RUN;
                    w_update     = 1'b1;
                end
            end
            S_RUN: begin
                w_next_cnt = w_wrap ? '0 : r_cnt + 1'b1;
                w_update   = w_wrap;
                if (!i_enable) begin
                    w_next_state = S_STOP;
                end
            end
            S_STOP: begin
                w_next_cnt = w_wrap ? '0 : r_cnt + 1'b1;
                if (i_enable) begin
                    w_next_state = S_RUN;
                    w_update     = w_wrap;
                end else if (w_wrap) begin
                    // Final period complete; no bank update on the way to IDLE,
                    // so a late load stays pending until the next start.
                    w_next_state = S_IDLE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Registered period_start: predict the cnt == 0 cycle of RUN one edge early.
    assign w_start = (w_next_state == S_RUN) && (w_next_cnt == '0);

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            r_state        <= S_IDLE;
            r_cnt          <= '0;
            r_period_start <= 1'b0;
        end else begin
            r_state        <= w_next_state;
            r_cnt          <= w_next_cnt;
            r_period_start <= w_start;
        end
    end

    always_ff @(posedge clk_div or posedge rst) begin
        if (rst) begin
            r_act_r   <= '0;
            r_act_g   <= '0;
            r_act_b   <= '0;
            r_pend_r  <= '0;
            r_pend_g  <= '0;
            r_pend_b  <= '0;
            r_pending <= 1'b0;
        end else if (w_update) begin
            // A load on the boundary edge bypasses the pending bank.
            if (i_load) begin
                r_act_r <= i_r_duty;
                r_act_g <= i_g_duty;
                r_act_b <= i_b_duty;
            end else if (r_pending) begin
                r_act_r <= r_pend_r;
                r_act_g <= r_pend_g;
                r_act_b <= r_pend_b;
            end
            r_pending <= 1'b0;
        end else if (i_load) begin
            r_pend_r  <= i_r_duty;
            r_pend_g  <= i_g_duty;
            r_pend_b  <= i_b_duty;
            r_pending <= 1'b1;
        end
    end

    assign o_pwm_r        = ((r_state != S_IDLE) && (r_cnt < r_act_r)) ^ INVERT;
    assign o_pwm_g        = ((r_state != S_IDLE) && (r_cnt < r_act_g)) ^ INVERT;
    assign o_pwm_b        = ((r_state != S_IDLE) && (r_cnt < r_act_b)) ^ INVERT;
    assign o_period_start = r_period_start;
    assign o_pending      = r_pending;

endmodule
